// File: rtl/result_dump_tx_pkg.sv
// Shared definitions for the result dump transmitter: memory geometry,
// frame header constant and the sequencer state encoding.
package result_dump_tx_pkg;

  localparam int MEM_AW = 13;
  localparam int MEM_DW = 8;
  localparam logic [7:0] HDR_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HDR    = 3'd1,
    RD     = 3'd2,
    RWAIT  = 3'd3,
    SEND   = 3'd4,
    TXWAIT = 3'd5,
    CSUM   = 3'd6,
    FIN    = 3'd7
  } state_t;

endpackage

// File: rtl/result_dump_tx_uart.sv
// 8N1 UART byte serializer, LSB first, idle high. idle is raised during the
// final cycle of the stop bit so a following byte can start after a short gap.
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] data,
  output logic       tx,
  output logic       idle
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = $clog2(10);
  localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(9);

  logic          active_r;
  logic [CW-1:0] clk_cnt_r;
  logic [BW-1:0] bit_cnt_r;
  logic [7:0]    shift_r;
  logic          tx_r;
  logic          last_tick_s;

  // Flag the last clock of the stop bit
  always_comb begin
    last_tick_s = 1'b0;
    if (active_r && (bit_cnt_r == BIT_LAST) && (clk_cnt_r == CLK_LAST)) begin
      last_tick_s = 1'b1;
    end else begin
      last_tick_s = 1'b0;
    end
  end

  assign idle = !active_r || last_tick_s;
  assign tx   = tx_r;

  // Bit timing: start bit on load, then shift data out LSB first, stop bit filled with ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_r  <= 1'b0;
      clk_cnt_r <= '0;
      bit_cnt_r <= '0;
      shift_r   <= 8'hFF;
      tx_r      <= 1'b1;
    end else if (load && idle) begin
      active_r  <= 1'b1;
      clk_cnt_r <= '0;
      bit_cnt_r <= '0;
      shift_r   <= data;
      tx_r      <= 1'b0;
    end else if (active_r) begin
      if (clk_cnt_r == CLK_LAST) begin
        clk_cnt_r <= '0;
        if (bit_cnt_r == BIT_LAST) begin
          active_r <= 1'b0;
          tx_r     <= 1'b1;
        end else begin
          bit_cnt_r <= bit_cnt_r + BW'(1);
          tx_r      <= shift_r[0];
          shift_r   <= {1'b1, shift_r[7:1]};
        end
      end else begin
        clk_cnt_r <= clk_cnt_r + CW'(1);
      end
    end
  end

endmodule

// File: rtl/result_dump_tx.sv
// Result dump transmitter: sends header 0xA5, N_RES bytes read from memory
// starting at BASE_ADDR, then the XOR checksum of the payload over a UART.
module result_dump_tx
  import result_dump_tx_pkg::*;
#(
  parameter int                N_RES        = 8,
  parameter logic [MEM_AW-1:0] BASE_ADDR    = 13'd1,
  parameter int                CLKS_PER_BIT = 868
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              mem_re,
  output logic [MEM_AW-1:0] mem_raddr,
  input  logic [MEM_DW-1:0] mem_dout,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int IW = $clog2(N_RES + 1);

  // The read window must fit below the top of the address space; there is no wrap
  if ((N_RES < 1) || ((int'(BASE_ADDR) + N_RES - 1) > 8191)) begin : g_range_chk
    $error("result_dump_tx: BASE_ADDR + N_RES - 1 exceeds 13'h1FFF");
  end

  state_t            state_r;
  state_t            next_s;
  logic [IW-1:0]     index_r;
  logic [7:0]        csum_r;
  logic [7:0]        byte_r;
  logic              csum_sent_r;
  logic              mem_re_r;
  logic [MEM_AW-1:0] mem_raddr_r;
  logic              busy_r;
  logic              done_r;
  logic              load_s;
  logic [7:0]        load_data_s;
  logic              ser_idle_s;

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_ser (
    .clk (clk),
    .rst (rst),
    .load(load_s),
    .data(load_data_s),
    .tx  (tx),
    .idle(ser_idle_s)
  );

  // Sequencer next state and serializer load selection
  always_comb begin
    next_s      = state_r;
    load_s      = 1'b0;
    load_data_s = 8'h00;
    case (state_r)
      IDLE: begin
        if (start) begin
          next_s = HDR;
        end else begin
          next_s = IDLE;
        end
      end
      HDR: begin
        load_s      = 1'b1;
        load_data_s = HDR_BYTE;
        next_s      = TXWAIT;
      end
      RD:    next_s = RWAIT;
      RWAIT: next_s = SEND;
      SEND: begin
        load_s      = 1'b1;
        load_data_s = byte_r;
        next_s      = TXWAIT;
      end
      TXWAIT: begin
        if (!ser_idle_s) begin
          next_s = TXWAIT;
        end else if (index_r < IW'(N_RES)) begin
          next_s = RD;
        end else if (!csum_sent_r) begin
          next_s = CSUM;
        end else begin
          next_s = FIN;
        end
      end
      CSUM: begin
        load_s      = 1'b1;
        load_data_s = csum_r;
        next_s      = TXWAIT;
      end
      FIN:     next_s = IDLE;
      default: next_s = IDLE;
    endcase
  end

  // State register plus registered status and memory strobes derived from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      mem_re_r    <= 1'b0;
      mem_raddr_r <= BASE_ADDR;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r  <= next_s;
      mem_re_r <= (next_s == RD);
      busy_r   <= (next_s != IDLE) && (next_s != FIN);
      done_r   <= (next_s == FIN);
      if (next_s == RD) begin
        mem_raddr_r <= BASE_ADDR + MEM_AW'(index_r);
      end
    end
  end

  // Payload index, captured byte and running checksum
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      index_r     <= '0;
      csum_r      <= 8'h00;
      byte_r      <= 8'h00;
      csum_sent_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            index_r     <= '0;
            csum_r      <= 8'h00;
            csum_sent_r <= 1'b0;
          end
        end
        RWAIT: begin
          byte_r <= mem_dout;
          csum_r <= csum_r ^ mem_dout;
        end
        SEND:    index_r <= index_r + IW'(1);
        CSUM:    csum_sent_r <= 1'b1;
        default: csum_sent_r <= csum_sent_r;
      endcase
    end
  end

  assign mem_re    = mem_re_r;
  assign mem_raddr = mem_raddr_r;
  assign busy      = busy_r;
  assign done      = done_r;

endmodule

// File: tb/tb_result_dump_tx.sv
// Bench for result_dump_tx: memory model, UART decoder and scoreboard of
// expected bytes / read addresses, exercising two parameterisations.
`timescale 1ns/1ps
module tb_result_dump_tx;

  localparam int CPB = 4;
  localparam int NR  = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic        re_a, re_b;
  logic [12:0] ra_a, ra_b;
  logic [7:0]  dout_a = 8'h00, dout_b = 8'h00;
  logic        tx_a, tx_b, busy_a, busy_b, done_a, done_b;

  logic [7:0]  mem [0:8191];
  logic [7:0]  exp_q [$];
  logic [12:0] addr_q [$];
  int          tests = 0, failed = 0;
  int          rx_cnt = 0, done_cnt = 0;
  logic        sel = 1'b0;
  logic        rx_act = 1'b0;
  int          rx_j = 0, rx_k = 0;
  logic [7:0]  rx_byte = 8'h00, exp_b = 8'h00;
  logic [12:0] exp_a = 13'd0;
  logic        prev_re = 1'b0, prev_done = 1'b0;

  wire         tx_m   = sel ? tx_b   : tx_a;
  wire         busy_m = sel ? busy_b : busy_a;
  wire         done_m = sel ? done_b : done_a;
  wire         re_m   = sel ? re_b   : re_a;
  wire  [12:0] ra_m   = sel ? ra_b   : ra_a;

  always #5 clk = ~clk;

  result_dump_tx #(.N_RES(NR), .BASE_ADDR(13'd1), .CLKS_PER_BIT(CPB)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .mem_re(re_a), .mem_raddr(ra_a),
    .mem_dout(dout_a), .tx(tx_a), .busy(busy_a), .done(done_a));

  result_dump_tx #(.N_RES(NR), .BASE_ADDR(13'h1FF8), .CLKS_PER_BIT(CPB)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .mem_re(re_b), .mem_raddr(ra_b),
    .mem_dout(dout_b), .tx(tx_b), .busy(busy_b), .done(done_b));

  // Synchronous-read memory: data valid one cycle after mem_re
  always @(posedge clk) begin
    if (re_a) dout_a <= mem[ra_a];
    if (re_b) dout_b <= mem[ra_b];
  end

  // Line monitor, read-address checker and UART decoder for the selected instance
  always @(negedge clk) begin
    if (rst) begin
      rx_act = 1'b0;
      prev_re = 1'b0;
      prev_done = 1'b0;
    end else begin
      tests++;
      if (!busy_m && tx_m !== 1'b1) begin
        failed++;
        $display("FAIL tx_idle_high: tx=%b busy=%b, required tx=1 while busy=0", tx_m, busy_m);
      end
      if (re_m) begin
        tests++;
        if (prev_re) begin
          failed++;
          $display("FAIL mem_re_pulse: mem_re high for 2+ cycles, required single-cycle pulse");
        end else if (addr_q.size() == 0) begin
          failed++;
          $display("FAIL mem_addr: unexpected read at %h, required no read", ra_m);
        end else begin
          exp_a = addr_q.pop_front();
          if (ra_m !== exp_a) begin
            failed++;
            $display("FAIL mem_addr: got %h, required %h", ra_m, exp_a);
          end
        end
      end
      prev_re = re_m;
      if (done_m) begin
        done_cnt++;
        tests++;
        if (busy_m !== 1'b0 || prev_done) begin
          failed++;
          $display("FAIL done_pulse: busy=%b prev_done=%b, required busy=0 and single cycle", busy_m, prev_done);
        end
      end
      prev_done = done_m;
      if (!rx_act) begin
        if (tx_m === 1'b0) begin
          rx_act = 1'b1;
          rx_j = 0;
        end
      end else begin
        rx_j++;
        if (rx_j % CPB == CPB / 2) begin
          rx_k = rx_j / CPB;
          if (rx_k == 0) begin
            tests++;
            if (tx_m !== 1'b0) begin
              failed++;
              $display("FAIL start_bit: got %b, required 0", tx_m);
              rx_act = 1'b0;
            end
          end else if (rx_k <= 8) begin
            rx_byte[rx_k-1] = tx_m;
          end else begin
            tests++;
            if (tx_m !== 1'b1) begin
              failed++;
              $display("FAIL stop_bit: got %b, required 1", tx_m);
            end
            tests++;
            if (exp_q.size() == 0) begin
              failed++;
              $display("FAIL rx_byte: unexpected byte %h, required none", rx_byte);
            end else begin
              exp_b = exp_q.pop_front();
              if (rx_byte !== exp_b) begin
                failed++;
                $display("FAIL rx_byte: got %h, required %h", rx_byte, exp_b);
              end
            end
            rx_cnt++;
            rx_act = 1'b0;
          end
        end
      end
    end
  end

  task automatic push_frame(input int base);
    logic [7:0] cs;
    cs = 8'h00;
    exp_q.push_back(8'hA5);
    for (int i = 0; i < NR; i++) begin
      exp_q.push_back(mem[base+i]);
      addr_q.push_back(13'(base + i));
      cs = cs ^ mem[base+i];
    end
    exp_q.push_back(cs);
  endtask

  task automatic pulse_start(input string name);
    @(negedge clk);
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    tests++;
    if (busy_m !== 1'b1) begin
      failed++;
      $display("FAIL %s_busy_rise: busy=%b, required 1", name, busy_m);
    end
  endtask

  task automatic wait_done(input string name, input int rx0, input int dc0);
    int n;
    n = 0;
    while (done_cnt == dc0 && n < 2000) begin
      @(posedge clk);
      #2;
      n++;
    end
    tests++;
    if (done_cnt == dc0) begin
      failed++;
      $display("FAIL %s_done_timeout: no done after %0d cycles, required one", name, n);
    end
    tests++;
    if (rx_cnt - rx0 != NR + 2 || exp_q.size() != 0 || addr_q.size() != 0) begin
      failed++;
      $display("FAIL %s_frame: bytes=%0d left=%0d addrs_left=%0d, required bytes=%0d left=0",
               name, rx_cnt - rx0, exp_q.size(), addr_q.size(), NR + 2);
    end
    tests++;
    if (done_cnt - dc0 != 1) begin
      failed++;
      $display("FAIL %s_done_count: got %0d, required 1", name, done_cnt - dc0);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    tests++; if (tx_a !== 1'b1) begin failed++; $display("FAIL rst_tx: got %b, required 1", tx_a); end
    tests++; if (busy_a !== 1'b0) begin failed++; $display("FAIL rst_busy: got %b, required 0", busy_a); end
    tests++; if (done_a !== 1'b0) begin failed++; $display("FAIL rst_done: got %b, required 0", done_a); end
    tests++; if (re_a !== 1'b0) begin failed++; $display("FAIL rst_mem_re: got %b, required 0", re_a); end
    tests++; if (ra_a !== 13'd1) begin failed++; $display("FAIL rst_raddr_a: got %h, required 0001", ra_a); end
    tests++; if (ra_b !== 13'h1FF8) begin failed++; $display("FAIL rst_raddr_b: got %h, required 1ff8", ra_b); end
    rst = 1'b0;
    repeat (5) @(negedge clk);
    tests++; if (busy_a !== 1'b0 || tx_a !== 1'b1) begin failed++; $display("FAIL post_rst_idle: busy=%b tx=%b, required 0/1", busy_a, tx_a); end
  endtask

  task automatic test_frame();
    int rx0, dc0;
    rx0 = rx_cnt; dc0 = done_cnt;
    push_frame(1);
    pulse_start("frame");
    wait_done("frame", rx0, dc0);
  endtask

  task automatic test_all_ff();
    int rx0, dc0;
    for (int i = 1; i <= NR; i++) mem[i] = 8'hFF;
    rx0 = rx_cnt; dc0 = done_cnt;
    push_frame(1);
    pulse_start("all_ff");
    wait_done("all_ff", rx0, dc0);
    for (int i = 1; i <= NR; i++) mem[i] = 8'(8'h11 * i);
  endtask

  task automatic test_held_start();
    int rx0, dc0;
    rx0 = rx_cnt; dc0 = done_cnt;
    push_frame(1);
    @(negedge clk); start_a = 1'b1;
    repeat (50) @(negedge clk);
    start_a = 1'b0;
    repeat (150) @(negedge clk);
    start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    wait_done("held_start", rx0, dc0);
    repeat (100) @(negedge clk);
    tests++;
    if (done_cnt - dc0 != 1 || rx_cnt - rx0 != NR + 2 || busy_a !== 1'b0) begin
      failed++;
      $display("FAIL held_start_single: dones=%0d bytes=%0d busy=%b, required 1/%0d/0",
               done_cnt - dc0, rx_cnt - rx0, busy_a, NR + 2);
    end
  endtask

  task automatic test_reset_mid();
    int rx0, dc0, n;
    rx0 = rx_cnt; dc0 = done_cnt; n = 0;
    push_frame(1);
    pulse_start("rst_mid");
    while (rx_cnt < rx0 + 4 && n < 1000) begin
      @(posedge clk); #2; n++;
    end
    tests++;
    if (rx_cnt < rx0 + 4) begin failed++; $display("FAIL rst_mid_progress: bytes=%0d, required 4", rx_cnt - rx0); end
    repeat (12) @(negedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    addr_q.delete();
    #1;
    tests++; if (tx_a !== 1'b1) begin failed++; $display("FAIL rst_mid_tx: got %b, required 1", tx_a); end
    tests++; if (busy_a !== 1'b0) begin failed++; $display("FAIL rst_mid_busy: got %b, required 0", busy_a); end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    tests++; if (done_cnt != dc0) begin failed++; $display("FAIL rst_mid_no_done: got %0d dones, required 0", done_cnt - dc0); end
    rx0 = rx_cnt; dc0 = done_cnt;
    push_frame(1);
    pulse_start("rst_recover");
    wait_done("rst_recover", rx0, dc0);
  endtask

  task automatic test_back_to_back();
    int rx0, dc0;
    rx0 = rx_cnt; dc0 = done_cnt;
    push_frame(1);
    pulse_start("b2b_first");
    wait_done("b2b_first", rx0, dc0);
    rx0 = rx_cnt; dc0 = done_cnt;
    push_frame(1);
    pulse_start("b2b_second");
    wait_done("b2b_second", rx0, dc0);
  endtask

  task automatic test_high_base();
    int rx0, dc0;
    @(negedge clk);
    sel = 1'b1;
    rx0 = rx_cnt; dc0 = done_cnt;
    push_frame(13'h1FF8);
    pulse_start("high_base");
    wait_done("high_base", rx0, dc0);
    @(negedge clk);
    sel = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 8'h00;
    for (int i = 1; i <= NR; i++) mem[i] = 8'(8'h11 * i);
    for (int i = 0; i < NR; i++) mem[8184+i] = 8'(8'h5A + 8'd37 * i);
    test_reset();
    test_frame();
    test_all_ff();
    test_held_start();
    test_reset_mid();
    test_back_to_back();
    test_high_base();
    repeat (10) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/result_dump_tx.md
RESULT_DUMP_TX -- requirements
Module: result_dump_tx

Interface
REQ-001 Parameter N_RES, default 8: number of result bytes read from memory per dump.
REQ-002 Parameter BASE_ADDR, default 13'd1: address of the first stored result byte.
REQ-003 Parameter CLKS_PER_BIT, default 868: clk cycles per UART bit.
REQ-004 clk  input  1  single clock; all state changes on posedge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 start  input  1  single-cycle request to begin one dump frame.
REQ-007 mem_re  output  1  memory read enable.
REQ-008 mem_raddr  output  13  memory read address.
REQ-009 mem_dout  input  8  memory read data, valid exactly 1 cycle after mem_re.
REQ-010 tx  output  1  UART line, 8N1, LSB first, idle high.
REQ-011 busy  output  1  high from the accepted start until the frame's last stop bit ends.
REQ-012 done  output  1  single-cycle pulse after the last stop bit.

Function
REQ-013 Frame: header 0xA5, then N_RES bytes from BASE_ADDR..BASE_ADDR+N_RES-1 in ascending order, then checksum = XOR of the N_RES payload bytes.
REQ-014 FSM states: IDLE, HDR, RD, RWAIT, SEND, TXWAIT, CSUM, FIN.
REQ-015 IDLE: start=1 -> HDR; busy rises the next cycle; the checksum register clears to 0; the byte index clears to 0.
REQ-016 HDR: load 0xA5 into the serializer -> TXWAIT.
REQ-017 RD: mem_re=1 for exactly one cycle, mem_raddr=BASE_ADDR+index -> RWAIT.
REQ-018 RWAIT: capture mem_dout and XOR it into the checksum -> SEND.
REQ-019 SEND: load the captured byte into the serializer, increment index -> TXWAIT.
REQ-020 TXWAIT: wait for the serializer's idle flag; then go to RD if index<N_RES, else to CSUM if the checksum is unsent, else to FIN.
REQ-021 CSUM: load the checksum byte -> TXWAIT.
REQ-022 FIN: done=1 for one cycle, busy=0 -> IDLE.
REQ-023 start while busy=1 is ignored and is not queued.
REQ-024 Each byte is 10 bit periods of CLKS_PER_BIT cycles each: start 0, d[0]..d[7], stop 1.
REQ-025 Inter-byte gap is at most 3 cycles of idle-high between a stop bit and the next start bit.
REQ-026 Address arithmetic is 13-bit unsigned.
REQ-027 BASE_ADDR+N_RES-1 shall not exceed 13'h1FFF; this is checked at elaboration, with no runtime wrap.
REQ-028 The bit counter and cycle counter widths are sized as $clog2 of their maximum values; no overflow is permitted.
REQ-029 mem_re=0 and mem_raddr holds its value in all states except RD.

Reset
REQ-030 rst=1 forces state IDLE, tx=1, busy=0, done=0, mem_re=0, mem_raddr=BASE_ADDR, checksum=0, index=0, and clears the serializer counters, all immediately.
REQ-031 Reset mid-frame abandons the frame with no done pulse; tx returns high within the same cycle.
REQ-032 After rst deasserts, the first start is accepted on the first posedge at which it is high.

Structure
REQ-033 The shared package holds HDR_BYTE=8'hA5, MEM_AW=13, MEM_DW=8, and the FSM state enum.
REQ-034 One sub-module, uart_tx_byte, implements the serializer with ports clk, rst, load, data[7:0], tx, idle.
REQ-035 result_dump_tx holds the FSM, the address/index counters and the checksum.

Verification
REQ-036 Bench uses CLKS_PER_BIT=4 and a memory model preloaded at addr 1..8 with 0x11,0x22,0x33,0x44,0x55,0x66,0x77,0x88; pulse start -> UART decoder receives A5 11 22 33 44 55 66 77 88 88, followed by one done pulse.
REQ-037 Memory all 0xFF, N_RES=8 -> checksum 0x00; the frame is A5, eight FF, then 00.
REQ-038 start held high for 50 cycles, then pulsed again mid-frame -> exactly one frame is sent.
REQ-039 rst asserted during the 4th payload byte -> tx=1 in the same cycle, busy=0, no done; a new start then yields a complete, correct frame.
REQ-040 Monitor the whole run -> mem_re is a single-cycle pulse per byte, addresses are 1..8 in order, and tx never goes low while busy=0.
REQ-041 BASE_ADDR=13'h1FF8, N_RES=8 -> addresses 1FF8..1FFF are read with no wrap, and the frame is correct.
